// File: rtl/pb_write_scheduler.sv
// rtl/pb_write_scheduler.sv - shares the pixel buffer write port between host writes and a run-fill engine
module pb_write_scheduler #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 4
) (
  input  logic              VGA_CLK,
  input  logic              RESET,
  input  logic              HOST_REQ,
  input  logic [ADDR_W-1:0] HOST_ADDR,
  input  logic [DATA_W-1:0] HOST_DATA,
  output logic              HOST_ACK,
  input  logic              FILL_START,
  input  logic              FILL_ABORT,
  input  logic [ADDR_W-1:0] FILL_BASE,
  input  logic [ADDR_W-1:0] FILL_LEN,
  input  logic [DATA_W-1:0] FILL_COLOR,
  output logic              FILL_BUSY,
  output logic              FILL_DONE,
  output logic [ADDR_W-1:0] PB_WA,
  output logic [DATA_W-1:0] PB_DATA,
  output logic              PB_WE
);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_t;

  localparam logic              LG_FILL = 1'b0;
  localparam logic              LG_HOST = 1'b1;
  localparam logic [ADDR_W-1:0] ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_ptr, remaining;
  logic [DATA_W-1:0] fill_color;
  logic              last_grant;
  logic              host_req, fill_req, host_grant, fill_grant;

  // Abort removes the fill requester in the same cycle, so it beats a final grant.
  always_comb begin
    host_req   = HOST_REQ && !RESET;
    fill_req   = (state == ST_FILL) && !FILL_ABORT;
    host_grant = host_req && (!fill_req || last_grant == LG_FILL);
    fill_grant = fill_req && !host_grant;
    HOST_ACK   = host_grant;

    state_nx = state;
    case (state)
      ST_IDLE: if (FILL_START) state_nx = (FILL_LEN == '0) ? ST_DONE : ST_FILL;
      ST_FILL: begin
        if (FILL_ABORT) state_nx = ST_DONE;
        else if (fill_grant && remaining == ONE) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      last_grant <= LG_FILL;
      addr_ptr   <= '0;
      remaining  <= '0;
      fill_color <= '0;
      FILL_BUSY  <= 1'b0;
      FILL_DONE  <= 1'b0;
      PB_WE      <= 1'b0;
      PB_WA      <= '0;
      PB_DATA    <= '0;
    end else begin
      state     <= state_nx;
      FILL_BUSY <= (state_nx != ST_IDLE);
      FILL_DONE <= (state_nx == ST_DONE);

      if (state == ST_IDLE && FILL_START) begin
        addr_ptr   <= FILL_BASE;
        remaining  <= FILL_LEN;
        fill_color <= FILL_COLOR;
      end else if (fill_grant) begin
        addr_ptr  <= addr_ptr + ONE;
        remaining <= remaining - ONE;
      end

      // Round-robin pointer only moves when both sides actually competed.
      if (host_req && fill_req) last_grant <= host_grant ? LG_HOST : LG_FILL;

      PB_WE <= host_grant || fill_grant;
      if (host_grant) begin
        PB_WA   <= HOST_ADDR;
        PB_DATA <= HOST_DATA;
      end else if (fill_grant) begin
        PB_WA   <= addr_ptr;
        PB_DATA <= fill_color;
      end
    end
  end

endmodule
